// File: rtl/branch_pkg.sv
// branch_pkg -- shared definitions for the branch unit.
//   BR_* : 5-bit BrOp codes. Any code with bit 4 set is a jump; BR_JUMP is
//          the canonical form of that prefix.
//   is_cond_op / is_jump_op : classify a BrOp code for the statistics counters.
package branch_pkg;

    localparam int BROP_W = 5;

    localparam logic [BROP_W-1:0] BR_NONE = 5'b00000;
    localparam logic [BROP_W-1:0] BR_BEQ  = 5'b01000;
    localparam logic [BROP_W-1:0] BR_BNE  = 5'b01001;
    localparam logic [BROP_W-1:0] BR_BLT  = 5'b01100;
    localparam logic [BROP_W-1:0] BR_BGE  = 5'b01101;
    localparam logic [BROP_W-1:0] BR_BLTU = 5'b01110;
    localparam logic [BROP_W-1:0] BR_BGEU = 5'b01111;
    localparam logic [BROP_W-1:0] BR_JUMP = 5'b10000;

    // Conditional branches live in 01xxx, minus the reserved pair 0101x.
    function automatic logic is_cond_op(input logic [BROP_W-1:0] op);
        return (op[4:3] == 2'b01) && (op[2:1] != 2'b01);
    endfunction

    // Only the top bit matters for jumps; the low bits are don't-care.
    function automatic logic is_jump_op(input logic [BROP_W-1:0] op);
        return op[4] == BR_JUMP[4];
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// branch_cmp -- operand comparator for the branch unit.
//   a_i, b_i : 32-bit operands (rs1, rs2)
//   eq_o     : a_i == b_i
//   lt_s_o   : a_i <  b_i, two's complement
//   lt_u_o   : a_i <  b_i, unsigned
module branch_cmp (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        eq_o,
    output logic        lt_s_o,
    output logic        lt_u_o
);

    assign eq_o   = (a_i == b_i);
    assign lt_s_o = ($signed(a_i) < $signed(b_i));
    assign lt_u_o = (a_i < b_i);

endmodule

// File: rtl/branch_unit.sv
// branch_unit -- branch decision plus statistics counters.
//   clk, rst_n  : clock, asynchronous active-low reset
//   BrOp        : branch operation code (see branch_pkg)
//   A, B        : rs1 / rs2 operands
//   en          : instruction-valid qualifier for NextPCSrc_q and counters
//   clr         : synchronous clear of all counters
//   NextPCSrc   : combinational take decision (1 = target, 0 = PC+4)
//   NextPCSrc_q : NextPCSrc captured on edges with en=1
//   cond_cnt    : conditional branches evaluated
//   taken_cnt   : conditional branches taken
//   jump_cnt    : unconditional jumps
//
// Qualifier semantics: there is no back-pressure. An instruction is counted
// and its decision captured exactly on each rising edge where en=1; en=0
// edges leave every register unchanged except that clr still zeroes counters.
module branch_unit
    import branch_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        BrOp,
    input  logic [31:0]       A,
    input  logic [31:0]       B,
    input  logic              en,
    input  logic              clr,
    output logic              NextPCSrc,
    output logic              NextPCSrc_q,
    output logic [CNT_W-1:0]  cond_cnt,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  jump_cnt
);

    logic eq, lt_s, lt_u;
    logic take;

    logic             nextpc_q, nextpc_d;
    logic [CNT_W-1:0] cond_q,  cond_d;
    logic [CNT_W-1:0] taken_q, taken_d;
    logic [CNT_W-1:0] jump_q,  jump_d;

    branch_cmp u_cmp (
        .a_i    (A),
        .b_i    (B),
        .eq_o   (eq),
        .lt_s_o (lt_s),
        .lt_u_o (lt_u)
    );

    // Decision is purely combinational so the fetch stage sees it same-cycle.
    always_comb begin
        take = 1'b0;
        if (is_jump_op(BrOp)) begin
            take = 1'b1;
        end else begin
            case (BrOp)
                BR_BEQ:  take = eq;
                BR_BNE:  take = ~eq;
                BR_BLT:  take = lt_s;
                BR_BGE:  take = ~lt_s;
                BR_BLTU: take = lt_u;
                BR_BGEU: take = ~lt_u;
                default: take = 1'b0;   // BR_NONE range and reserved codes
            endcase
        end
    end

    assign NextPCSrc = take;

    always_comb begin
        nextpc_d = en ? take : nextpc_q;
        cond_d   = cond_q;
        taken_d  = taken_q;
        jump_d   = jump_q;
        // clr wins over any increment on the same edge; it never touches nextpc.
        if (clr) begin
            cond_d  = '0;
            taken_d = '0;
            jump_d  = '0;
        end else if (en) begin
            if (is_cond_op(BrOp)) begin
                cond_d = cond_q + CNT_W'(1);
                if (take) begin
                    taken_d = taken_q + CNT_W'(1);
                end
            end
            if (is_jump_op(BrOp)) begin
                jump_d = jump_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nextpc_q <= 1'b0;
            cond_q   <= '0;
            taken_q  <= '0;
            jump_q   <= '0;
        end else begin
            nextpc_q <= nextpc_d;
            cond_q   <= cond_d;
            taken_q  <= taken_d;
            jump_q   <= jump_d;
        end
    end

    assign NextPCSrc_q = nextpc_q;
    assign cond_cnt    = cond_q;
    assign taken_cnt   = taken_q;
    assign jump_cnt    = jump_q;

endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit -- directed and random checks of branch_unit against a
// behavioural reference model. A narrow counter width makes wrap reachable.
module tb_branch_unit;

    localparam int CNT_W = 4;
    localparam int CNT_MOD = 1 << CNT_W;

    logic             clk;
    logic             rst_n;
    logic [4:0]       BrOp;
    logic [31:0]      A;
    logic [31:0]      B;
    logic             en;
    logic             clr;
    logic             NextPCSrc;
    logic             NextPCSrc_q;
    logic [CNT_W-1:0] cond_cnt;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] jump_cnt;

    int tests_run;
    int tests_failed;

    // Reference model state
    bit m_q;
    int m_cond, m_taken, m_jump;

    branch_unit #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .BrOp        (BrOp),
        .A           (A),
        .B           (B),
        .en          (en),
        .clr         (clr),
        .NextPCSrc   (NextPCSrc),
        .NextPCSrc_q (NextPCSrc_q),
        .cond_cnt    (cond_cnt),
        .taken_cnt   (taken_cnt),
        .jump_cnt    (jump_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic longint to_signed(input logic [31:0] v);
        longint u;
        u = longint'(v);
        return (u >= 64'sd2147483648) ? (u - 64'sd4294967296) : u;
    endfunction

    function automatic bit ref_take(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        int code;
        sa = to_signed(a);
        sb = to_signed(b);
        ua = longint'(a);
        ub = longint'(b);
        code = int'(op);
        if (code >= 16) return 1'b1;
        case (code)
            8:  return ua == ub;
            9:  return ua != ub;
            12: return sa <  sb;
            13: return sa >= sb;
            14: return ua <  ub;
            15: return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit ref_is_cond(input logic [4:0] op);
        int code;
        code = int'(op);
        return (code == 8) || (code == 9) || (code >= 12 && code <= 15);
    endfunction

    // Model of one rising edge using the currently applied inputs.
    task automatic model_edge();
        bit t;
        t = ref_take(BrOp, A, B);
        if (en) m_q = t;
        if (clr) begin
            m_cond = 0; m_taken = 0; m_jump = 0;
        end else if (en) begin
            if (ref_is_cond(BrOp)) begin
                m_cond = (m_cond + 1) % CNT_MOD;
                if (t) m_taken = (m_taken + 1) % CNT_MOD;
            end
            if (int'(BrOp) >= 16) m_jump = (m_jump + 1) % CNT_MOD;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".q"},     64'(NextPCSrc_q), 64'(m_q));
        check({tag, ".cond"},  64'(cond_cnt),    64'(m_cond));
        check({tag, ".taken"}, 64'(taken_cnt),   64'(m_taken));
        check({tag, ".jump"},  64'(jump_cnt),    64'(m_jump));
    endtask

    // ---------------- driver ----------------
    // Called right after a falling edge: apply inputs, check the combinational
    // decision, clock once, then check every registered output.
    task automatic step(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic e, input logic c);
        BrOp = op; A = a; B = b; en = e; clr = c;
        #1;
        check({tag, ".comb"}, 64'(NextPCSrc), 64'(ref_take(op, a, b)));
        @(posedge clk);
        model_edge();
        #1;
        check_regs(tag);
        @(negedge clk);
    endtask

    task automatic comb_only(input string tag, input logic [4:0] op, input logic [31:0] a,
                             input logic [31:0] b, input bit exp);
        BrOp = op; A = a; B = b;
        #1;
        check(tag, 64'(NextPCSrc), 64'(exp));
    endtask

    logic [4:0] op_pool [13];

    initial begin
        tests_run = 0; tests_failed = 0;
        m_q = 0; m_cond = 0; m_taken = 0; m_jump = 0;
        op_pool = '{5'd0, 5'd5, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13,
                    5'd14, 5'd15, 5'd16, 5'd23, 5'd31};
        rst_n = 1'b0; BrOp = '0; A = '0; B = '0; en = 1'b0; clr = 1'b0;

        // Reset state and directed decode with fixed expectations (reset held).
        @(negedge clk);
        check_regs("reset");
        comb_only("none_eq",   5'b00000, 32'd10, 32'd10, 1'b0);
        comb_only("beq_eq",    5'b01000, 32'd15, 32'd15, 1'b1);
        comb_only("bne_ne",    5'b01001, 32'd20, 32'd25, 1'b1);
        comb_only("blt_neg",   5'b01100, -32'sd10, 32'd5, 1'b1);
        comb_only("bge_eq",    5'b01101, 32'd30, 32'd30, 1'b1);
        comb_only("bltu_big",  5'b01110, 32'hFFFF_FFFF, 32'd100, 1'b0);
        comb_only("blt_big",   5'b01100, 32'hFFFF_FFFF, 32'd100, 1'b1);
        comb_only("bgeu_gt",   5'b01111, 32'd50, 32'd25, 1'b1);
        comb_only("jal_zero",  5'b10000, 32'd0, 32'd0, 1'b1);
        comb_only("rsv_01010", 5'b01010, 32'd7, 32'd7, 1'b0);
        comb_only("rsv_01011", 5'b01011, 32'd1, 32'd9, 1'b0);
        check_regs("reset_hold");

        // Release reset between edges; first update on the next rising edge.
        rst_n = 1'b1;
        @(negedge clk);
        step("beq_t", 5'b01000, 32'd15, 32'd15, 1'b1, 1'b0);
        step("bne_n", 5'b01001, 32'd20, 32'd20, 1'b1, 1'b0);
        step("jal",   5'b10000, 32'd0,  32'd0,  1'b1, 1'b0);
        check(("cnt3.cond"),  64'(cond_cnt),  64'd2);
        check(("cnt3.taken"), 64'(taken_cnt), 64'd1);
        check(("cnt3.jump"),  64'(jump_cnt),  64'd1);
        step("hold_en0", 5'b01000, 32'd3, 32'd4, 1'b0, 1'b0);

        // clr overrides a simultaneous jump; nextpc still loads.
        step("clr_jal", 5'b10000, 32'd0, 32'd0, 1'b1, 1'b1);
        check("clr.cond", 64'(cond_cnt), 64'd0);
        check("clr.q",    64'(NextPCSrc_q), 64'd1);

        // Walk cond_cnt to its max value, then one more branch wraps it to 0.
        for (int i = 0; i < CNT_MOD - 1; i++) begin
            step("fill", 5'b01001, 32'(i), 32'(i + 1), 1'b1, 1'b0);
        end
        check("max.cond", 64'(cond_cnt), 64'(CNT_MOD - 1));
        step("wrap", 5'b01000, 32'd1, 32'd2, 1'b1, 1'b0);
        check("wrap.cond", 64'(cond_cnt), 64'd0);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            logic [4:0]  op;
            logic [31:0] a, b;
            op = op_pool[$urandom_range(0, 12)];
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = 32'($urandom_range(0, 8));
                default: b = $urandom;
            endcase
            step("rand", op, a, b, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
        end

        // Ensure nonzero counters, then assert reset between edges.
        step("pre_rst", 5'b10000, 32'd0, 32'd0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        m_q = 0; m_cond = 0; m_taken = 0; m_jump = 0;
        #1;
        check_regs("async_rst");
        comb_only("rst_comb1", 5'b01110, 32'd1, 32'd2, 1'b1);
        comb_only("rst_comb2", 5'b01101, 32'd1, 32'd2, 1'b0);
        // An edge while held in reset must not update anything.
        BrOp = 5'b10000; en = 1'b1; clr = 1'b0;
        @(posedge clk);
        #1;
        check_regs("rst_edge");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 5'b01000, 32'd9, 32'd9, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
